// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, default sizes and byte-merge helper for multi_port_main_memory
package mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } mem_state_t;

    localparam int MEM_DATA_WIDTH = 32;
    localparam int MEM_DEPTH      = 2048;
    localparam int BE_WIDTH       = MEM_DATA_WIDTH / 8;
    localparam int CNT_WIDTH      = $clog2(MEM_DEPTH);

    // Byte-lane merge; callers loop over lanes so the helper stays width-independent.
    function automatic logic [7:0] be_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/mem_read_pipe.sv
// rtl/mem_read_pipe.sv - per-port read pipeline: LATENCY stages of valid/oob/data
module mem_read_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic                  oob_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic                  oob_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    if (LATENCY == 0) begin : g_comb
        assign valid_o = valid_i;
        assign oob_o   = valid_i & oob_i;
        assign data_o  = data_i;
    end else begin : g_pipe
        logic [LATENCY-1:0]    valid_q;
        logic [LATENCY-1:0]    oob_q;
        logic [DATA_WIDTH-1:0] data_q [LATENCY];

        // Data stages only load behind a valid so the output holds between reads.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= '0;
                oob_q   <= '0;
                for (int s = 0; s < LATENCY; s++) begin
                    data_q[s] <= '0;
                end
            end else begin
                valid_q[0] <= valid_i;
                oob_q[0]   <= valid_i & oob_i;
                if (valid_i) begin
                    data_q[0] <= data_i;
                end
                for (int s = 1; s < LATENCY; s++) begin
                    valid_q[s] <= valid_q[s-1];
                    oob_q[s]   <= oob_q[s-1];
                    if (valid_q[s-1]) begin
                        data_q[s] <= data_q[s-1];
                    end
                end
            end
        end

        assign valid_o = valid_q[LATENCY-1];
        assign oob_o   = oob_q[LATENCY-1];
        assign data_o  = data_q[LATENCY-1];
    end

endmodule

// File: rtl/multi_port_main_memory.sv
// rtl/multi_port_main_memory.sv - multi-read-port word memory with byte-enable writes and clear sequencer
module multi_port_main_memory
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int DEPTH          = 2048,
    parameter int NUM_RD         = 2,
    parameter int RD_LATENCY     = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD-1:0]            rd_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_valid,
    output logic [NUM_RD-1:0]            rd_oob,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic [DATA_WIDTH/8-1:0]      wr_be,
    output logic                         wr_oob,
    output logic                         ready
);

    localparam int                    BE_W     = DATA_WIDTH / 8;
    localparam int                    CNT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
    localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
    logic             ready_q, ready_d;
    logic             wr_oob_q, wr_oob_d;

    logic                  wr_in_range;
    logic                  wr_commit;
    logic [CNT_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_old;
    logic [DATA_WIDTH-1:0] wr_merged;

    always_comb begin
        wr_in_range = wr_addr < DEPTH_A;
        wr_idx      = wr_addr[CNT_W-1:0];
        wr_commit   = ready_q & wr_en & wr_in_range;
        wr_oob_d    = ready_q & wr_en & ~wr_in_range;
        wr_old      = mem_q[wr_idx];
        wr_merged   = wr_old;
        for (int b = 0; b < BE_W; b++) begin
            wr_merged[8*b +: 8] = be_merge(wr_old[8*b +: 8], wr_data[8*b +: 8], wr_be[b]);
        end
    end

    // The array has no reset; the clear sequencer is the only way to zero it.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_commit) begin
            mem_q[wr_idx] <= wr_merged;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ready_d   = ready_q;
        case (state_q)
            CLEAR: begin
                ready_d = 1'b0;
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = READY;
                    ready_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + CNT_W'(1);
                end
            end
            READY: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            wr_oob_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
            wr_oob_q  <= wr_oob_d;
        end
    end

    assign ready  = ready_q;
    assign wr_oob = wr_oob_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [CNT_W-1:0]      idx;
        logic                  in_range;
        logic                  fwd;
        logic                  req;
        logic [DATA_WIDTH-1:0] word;

        // Registered reads see the write landing on the same edge (write-first).
        always_comb begin
            addr     = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            idx      = addr[CNT_W-1:0];
            in_range = addr < DEPTH_A;
            fwd      = (RD_LATENCY != 0) && wr_commit && (wr_addr == addr);
            req      = ready_q & rd_en[i];
            if (!in_range) begin
                word = '0;
            end else if (fwd) begin
                word = wr_merged;
            end else begin
                word = mem_q[idx];
            end
        end

        mem_read_pipe #(
            .DATA_WIDTH(DATA_WIDTH),
            .LATENCY   (RD_LATENCY)
        ) u_read_pipe (
            .clk    (clk),
            .rst_n  (rst_n),
            .valid_i(req),
            .oob_i  (~in_range),
            .data_i (word),
            .valid_o(rd_valid[i]),
            .oob_o  (rd_oob[i]),
            .data_o (rd_data[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_multi_port_main_memory.sv
// tb/tb_multi_port_main_memory.sv - self-checking bench for multi_port_main_memory
module tb_multi_port_main_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [31:0] data;
        logic        oob;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb_q [3][$];
    logic [31:0] model_b [2048];

    // Instance A: 16 words, two ports, one-cycle reads
    logic        rst_a_n;
    logic [1:0]  rd_en_a;
    logic [63:0] rd_addr_a;
    logic [63:0] rd_data_a;
    logic [1:0]  rd_valid_a;
    logic [1:0]  rd_oob_a;
    logic        wr_en_a;
    logic [31:0] wr_addr_a;
    logic [31:0] wr_data_a;
    logic [3:0]  wr_be_a;
    logic        wr_oob_a;
    logic        ready_a;

    // Instance B: 2048 words, three ports, three-cycle reads
    logic        rst_b_n;
    logic [2:0]  rd_en_b;
    logic [95:0] rd_addr_b;
    logic [95:0] rd_data_b;
    logic [2:0]  rd_valid_b;
    logic [2:0]  rd_oob_b;
    logic        wr_en_b;
    logic [31:0] wr_addr_b;
    logic [31:0] wr_data_b;
    logic [3:0]  wr_be_b;
    logic        wr_oob_b;
    logic        ready_b;

    multi_port_main_memory #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .NUM_RD(2), .RD_LATENCY(1), .CLEAR_ON_RESET(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_a_n), .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .rd_oob(rd_oob_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .wr_be(wr_be_a), .wr_oob(wr_oob_a), .ready(ready_a)
    );

    multi_port_main_memory #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(2048), .NUM_RD(3), .RD_LATENCY(3), .CLEAR_ON_RESET(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_b_n), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .rd_oob(rd_oob_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .wr_be(wr_be_b), .wr_oob(wr_oob_b), .ready(ready_b)
    );

    task automatic test_reset();
        bit bad;
        repeat (2) @(negedge clk);
        checks++;
        if ({rd_data_a, rd_valid_a, rd_oob_a, wr_oob_a, ready_a} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_a got data=%h valid=%b oob=%b wr_oob=%b ready=%b exp all 0",
                     rd_data_a, rd_valid_a, rd_oob_a, wr_oob_a, ready_a);
        end
        checks++;
        if (ready_b !== 1'b0 || rd_valid_b !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs_b got ready=%b valid=%b exp 0/000", ready_b, rd_valid_b);
        end
        rst_a_n   = 1'b1;
        rst_b_n   = 1'b1;
        wr_en_a   = 1'b1;
        wr_addr_a = 32'd20;
        wr_data_a = 32'hFFFF_FFFF;
        wr_be_a   = 4'hF;
        rd_en_a   = 2'b11;
        rd_addr_a = {32'd5, 32'd5};
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ready_a !== 1'b0 || wr_oob_a !== 1'b0 || rd_valid_a !== 2'b00) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL clear_busy got ready/wr_oob/rd_valid active during clear exp all 0");
        end
        wr_en_a = 1'b0;
        rd_en_a = 2'b00;
        @(negedge clk);
        checks++;
        if (ready_a !== 1'b1) begin
            errors++;
            $display("FAIL clear_done got ready=%b exp 1 after 16 cycles", ready_a);
        end
        rd_en_a = 2'b01;
        rd_addr_a[31:0] = 32'd5;
        @(negedge clk);
        checks++;
        if (rd_valid_a !== 2'b01 || rd_data_a[31:0] !== 32'h0 || rd_oob_a !== 2'b00) begin
            errors++;
            $display("FAIL cleared_word5 got valid=%b data=%h exp 01/00000000", rd_valid_a, rd_data_a[31:0]);
        end
        rd_en_a = 2'b00;
    endtask

    task automatic test_byte_enable();
        @(negedge clk);
        wr_en_a = 1'b1; wr_addr_a = 32'd3; wr_data_a = 32'hDEAD_BEEF; wr_be_a = 4'b1111;
        @(negedge clk);
        wr_data_a = 32'h0000_AA00; wr_be_a = 4'b0010;
        @(negedge clk);
        wr_en_a = 1'b0;
        rd_en_a = 2'b01; rd_addr_a[31:0] = 32'd3;
        @(negedge clk);
        checks++;
        if (rd_valid_a !== 2'b01 || rd_data_a[31:0] !== 32'hDEAD_AAEF) begin
            errors++;
            $display("FAIL byte_enable got valid=%b data=%h exp 01/deadaaef", rd_valid_a, rd_data_a[31:0]);
        end
        rd_en_a = 2'b00;
    endtask

    task automatic test_collision();
        @(negedge clk);
        wr_en_a = 1'b1; wr_addr_a = 32'd7; wr_data_a = 32'h1234_5678; wr_be_a = 4'b1111;
        rd_en_a = 2'b10; rd_addr_a[63:32] = 32'd7;
        @(negedge clk);
        checks++;
        if (rd_valid_a !== 2'b10 || rd_data_a[63:32] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL collision_full got valid=%b data=%h exp 10/12345678", rd_valid_a, rd_data_a[63:32]);
        end
        wr_data_a = 32'h0000_00FF; wr_be_a = 4'b0001;
        rd_en_a = 2'b11; rd_addr_a = {32'd7, 32'd7};
        @(negedge clk);
        checks++;
        if (rd_valid_a !== 2'b11 || rd_data_a !== {32'h1234_56FF, 32'h1234_56FF}) begin
            errors++;
            $display("FAIL collision_partial got valid=%b data=%h exp 11/123456ff123456ff", rd_valid_a, rd_data_a);
        end
        wr_en_a = 1'b0;
        rd_en_a = 2'b00;
    endtask

    task automatic test_boundary();
        @(negedge clk);
        wr_en_a = 1'b1; wr_addr_a = 32'd16; wr_data_a = 32'hFFFF_FFFF; wr_be_a = 4'hF;
        rd_en_a = 2'b11; rd_addr_a = {32'd7, 32'd16};
        @(negedge clk);
        checks++;
        if (rd_valid_a !== 2'b11 || rd_oob_a !== 2'b01 || rd_data_a !== {32'h1234_56FF, 32'h0}
            || wr_oob_a !== 1'b1) begin
            errors++;
            $display("FAIL boundary_oob got valid=%b oob=%b data=%h wr_oob=%b exp 11/01/123456ff00000000/1",
                     rd_valid_a, rd_oob_a, rd_data_a, wr_oob_a);
        end
        wr_en_a = 1'b0;
        rd_en_a = 2'b00;
        @(negedge clk);
        checks++;
        if (wr_oob_a !== 1'b0 || rd_valid_a !== 2'b00 || rd_oob_a !== 2'b00
            || rd_data_a !== {32'h1234_56FF, 32'h0}) begin
            errors++;
            $display("FAIL boundary_hold got wr_oob=%b valid=%b oob=%b data=%h exp 0/00/00/123456ff00000000",
                     wr_oob_a, rd_valid_a, rd_oob_a, rd_data_a);
        end
    endtask

    task automatic test_reset_mid_clear();
        bit bad;
        @(negedge clk);
        rst_a_n = 1'b0;
        #1;
        checks++;
        if ({rd_data_a, rd_valid_a, rd_oob_a, wr_oob_a, ready_a} !== '0) begin
            errors++;
            $display("FAIL async_reset_a got data=%h ready=%b exp 0/0", rd_data_a, ready_a);
        end
        @(negedge clk);
        rst_a_n = 1'b1;
        repeat (9) @(negedge clk);
        rst_a_n = 1'b0;
        #1;
        checks++;
        if (ready_a !== 1'b0 || rd_valid_a !== 2'b00) begin
            errors++;
            $display("FAIL reset_at_count9 got ready=%b valid=%b exp 0/00", ready_a, rd_valid_a);
        end
        @(negedge clk);
        rst_a_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ready_a !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL clear_restart got ready=1 early exp 0 for 16 cycles");
        end
        @(negedge clk);
        checks++;
        if (ready_a !== 1'b1) begin
            errors++;
            $display("FAIL clear_restart_done got ready=%b exp 1", ready_a);
        end
        rd_en_a = 2'b01; rd_addr_a[31:0] = 32'd3;
        @(negedge clk);
        checks++;
        if (rd_valid_a !== 2'b01 || rd_data_a[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL recleared_word3 got valid=%b data=%h exp 01/00000000", rd_valid_a, rd_data_a[31:0]);
        end
        rd_en_a = 2'b00;
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] a;
        for (int i = 0; i < 2200 && ready_b !== 1'b1; i++) @(negedge clk);
        checks++;
        if (ready_b !== 1'b1) begin
            errors++;
            $display("FAIL ready_b_timeout got ready=%b exp 1", ready_b);
        end
        for (int i = 0; i < 2048; i++) model_b[i] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr_en_b = 1'b1; wr_addr_b = i; wr_data_b = 32'h1111_1111 * (i + 1); wr_be_b = 4'hF;
            model_b[i] = 32'h1111_1111 * (i + 1);
        end
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            wr_en_b = 1'b0;
            for (int p = 0; p < 3; p++) begin
                if (rd_valid_b[p] === 1'b1) begin
                    checks++;
                    if (sb_q[p].size() == 0) begin
                        errors++;
                        $display("FAIL b2b_unexpected port %0d got data=%h exp no valid", p, rd_data_b[p*32 +: 32]);
                    end else begin
                        e = sb_q[p].pop_front();
                        if (rd_data_b[p*32 +: 32] !== e.data || rd_oob_b[p] !== e.oob || cyc - e.cyc != 2) begin
                            errors++;
                            $display("FAIL b2b_read port %0d got data=%h oob=%b lat=%0d exp %h/%b/2",
                                     p, rd_data_b[p*32 +: 32], rd_oob_b[p], cyc - e.cyc, e.data, e.oob);
                        end
                    end
                end
            end
            rd_en_b = 3'b000;
            if (c < 15) begin
                for (int p = 0; p < 3; p++) begin
                    a = (c + p) % 3;
                    rd_en_b[p] = 1'b1;
                    rd_addr_b[p*32 +: 32] = a;
                    e.data = model_b[a]; e.oob = 1'b0; e.cyc = cyc + 1;
                    sb_q[p].push_back(e);
                end
            end
        end
        checks++;
        if (sb_q[0].size() + sb_q[1].size() + sb_q[2].size() != 0) begin
            errors++;
            $display("FAIL b2b_drain got %0d pending exp 0", sb_q[0].size() + sb_q[1].size() + sb_q[2].size());
        end
    endtask

    task automatic test_oob_scan();
        exp_t        e;
        int          idx;
        logic [31:0] oob_addr [3];
        oob_addr[0] = 32'd2048;
        oob_addr[1] = 32'hFFFF_FFFF;
        oob_addr[2] = 32'd2050;
        for (int c = 0; c < 692; c++) begin
            @(negedge clk);
            for (int p = 0; p < 3; p++) begin
                if (rd_valid_b[p] === 1'b1) begin
                    checks++;
                    if (sb_q[p].size() == 0) begin
                        errors++;
                        $display("FAIL scan_unexpected port %0d got data=%h exp no valid", p, rd_data_b[p*32 +: 32]);
                    end else begin
                        e = sb_q[p].pop_front();
                        if (rd_data_b[p*32 +: 32] !== e.data || rd_oob_b[p] !== e.oob) begin
                            errors++;
                            $display("FAIL scan_read port %0d got data=%h oob=%b exp %h/%b",
                                     p, rd_data_b[p*32 +: 32], rd_oob_b[p], e.data, e.oob);
                        end
                    end
                end
            end
            if (c == 1) begin
                checks++;
                if (wr_oob_b !== 1'b1) begin
                    errors++;
                    $display("FAIL wr_oob_pulse got %b exp 1", wr_oob_b);
                end
            end
            if (c == 2) begin
                checks++;
                if (wr_oob_b !== 1'b0) begin
                    errors++;
                    $display("FAIL wr_oob_single got %b exp 0", wr_oob_b);
                end
            end
            wr_en_b = (c == 0); wr_addr_b = 32'hFFFF_FFFF; wr_data_b = 32'h5555_5555; wr_be_b = 4'hF;
            rd_en_b = 3'b000;
            for (int p = 0; p < 3; p++) begin
                if (c == 0) begin
                    rd_en_b[p] = 1'b1;
                    rd_addr_b[p*32 +: 32] = oob_addr[p];
                    e.data = 32'h0; e.oob = 1'b1; e.cyc = cyc + 1;
                    sb_q[p].push_back(e);
                end else begin
                    idx = (c - 1) * 3 + p;
                    if (c <= 683 && idx < 2048) begin
                        rd_en_b[p] = 1'b1;
                        rd_addr_b[p*32 +: 32] = idx;
                        e.data = model_b[idx]; e.oob = 1'b0; e.cyc = cyc + 1;
                        sb_q[p].push_back(e);
                    end
                end
            end
        end
        checks++;
        if (sb_q[0].size() + sb_q[1].size() + sb_q[2].size() != 0) begin
            errors++;
            $display("FAIL scan_drain got %0d pending exp 0", sb_q[0].size() + sb_q[1].size() + sb_q[2].size());
        end
    endtask

    task automatic test_reset_inflight();
        bit bad;
        @(negedge clk);
        rd_en_b = 3'b111; rd_addr_b = {32'd2, 32'd1, 32'd0};
        @(negedge clk);
        @(negedge clk);
        rd_en_b = 3'b000;
        rst_b_n = 1'b0;
        #1;
        checks++;
        if ({rd_data_b, rd_valid_b, rd_oob_b, wr_oob_b, ready_b} !== '0) begin
            errors++;
            $display("FAIL inflight_reset got data=%h valid=%b ready=%b exp 0/000/0", rd_data_b, rd_valid_b, ready_b);
        end
        @(negedge clk);
        rst_b_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rd_valid_b !== 3'b000 || ready_b !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stale_valid got rd_valid or ready after reset exp none");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        rd_en_a = '0; rd_addr_a = '0; wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0; wr_be_a = '0;
        rd_en_b = '0; rd_addr_b = '0; wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0; wr_be_b = '0;
        test_reset();
        test_byte_enable();
        test_collision();
        test_boundary();
        test_reset_mid_clear();
        test_back_to_back();
        test_oob_scan();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
